// File: rtl/sdram_init_seq.sv
// Power-up sequencer for the cartridge SDRAM: waits for PLL lock, holds the power-up delay,
// then issues PRECHARGE ALL, AUTO REFRESH x N and LOAD MODE before handing over the bus.
module sdram_init_seq #(
    parameter int          CLK_MHZ       = 133,
    parameter int          POWERUP_US    = 200,
    parameter int          TRP           = 3,
    parameter int          TRFC          = 9,
    parameter int          TMRD          = 2,
    parameter int          REFRESH_COUNT = 2,
    parameter logic [12:0] MODE_REG      = 13'h033,
    parameter int          ADDR_W        = 13,
    parameter int          BA_W          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    output logic              sd_cke,
    output logic              sd_cs_n,
    output logic              sd_ras_n,
    output logic              sd_cas_n,
    output logic              sd_we_n,
    output logic [BA_W-1:0]   sd_ba,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              init_done,
    output logic [3:0]        dbg_state
);

    localparam int P     = POWERUP_US * CLK_MHZ;
    localparam int MAX_A = (P > TRFC) ? P : TRFC;
    localparam int MAX_B = (TRP > TMRD) ? TRP : TMRD;
    localparam int MAXV  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXV) + 1;
    localparam int RW    = $clog2(REFRESH_COUNT + 1);

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    typedef enum logic [3:0] {
        WAIT_LOCK = 4'd0,
        POWERUP   = 4'd1,
        PRE       = 4'd2,
        WAIT_RP   = 4'd3,
        REF       = 4'd4,
        WAIT_RFC  = 4'd5,
        LMR       = 4'd6,
        WAIT_MRD  = 4'd7,
        DONE      = 4'd8
    } state_t;

    state_t            state, next_state;
    logic              lock_ff, lock_s;
    logic [CW-1:0]     cnt, cnt_load;
    logic [RW-1:0]     ref_cnt;
    logic              cke_d, done_d;
    logic [3:0]        cmd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BA_W-1:0]   ba_d;

    assign dbg_state = state;

    // State register, shared wait counter (loaded on state entry) and refresh counter
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_ff <= 1'b0;
            lock_s  <= 1'b0;
            state   <= WAIT_LOCK;
            cnt     <= '0;
            ref_cnt <= RW'(REFRESH_COUNT);
        end else begin
            lock_ff <= pll_locked;
            lock_s  <= lock_ff;
            state   <= next_state;
            if (next_state != state)
                cnt <= cnt_load;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == WAIT_LOCK)
                ref_cnt <= RW'(REFRESH_COUNT);
            else if (state == REF)
                ref_cnt <= ref_cnt - 1'b1;
        end
    end

    // Wait states last (n-1) extra cycles after their one-cycle command, hence the -2 loads
    always_comb begin
        next_state = state;
        if (!lock_s) begin
            next_state = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: next_state = POWERUP;
                POWERUP:   if (cnt == '0) next_state = PRE;
                PRE:       next_state = WAIT_RP;
                WAIT_RP:   if (cnt == '0) next_state = REF;
                REF:       next_state = WAIT_RFC;
                WAIT_RFC:  if (cnt == '0) next_state = (ref_cnt == '0) ? LMR : REF;
                LMR:       next_state = WAIT_MRD;
                WAIT_MRD:  if (cnt == '0) next_state = DONE;
                DONE:      next_state = DONE;
                default:   next_state = WAIT_LOCK;
            endcase
        end
        case (next_state)
            POWERUP:  cnt_load = CW'(P - 1);
            WAIT_RP:  cnt_load = CW'(TRP - 2);
            WAIT_RFC: cnt_load = CW'(TRFC - 2);
            WAIT_MRD: cnt_load = CW'(TMRD - 2);
            default:  cnt_load = '0;
        endcase
    end

    // Output decode; a lost lock forces reset values on the same edge that enters WAIT_LOCK
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        done_d = 1'b0;
        if (!lock_s) begin
            cke_d = 1'b0;
            cmd_d = CMD_INHIBIT;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cke_d = 1'b0;
                    cmd_d = CMD_INHIBIT;
                end
                PRE: begin
                    cmd_d      = CMD_PRE;
                    addr_d[10] = 1'b1;
                end
                REF:  cmd_d = CMD_REF;
                LMR: begin
                    cmd_d  = CMD_LMR;
                    addr_d = ADDR_W'(MODE_REG);
                end
                DONE: begin
                    cmd_d  = CMD_INHIBIT;
                    done_d = 1'b1;
                end
                default: cmd_d = CMD_NOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sd_cke    <= 1'b0;
            sd_cs_n   <= 1'b1;
            sd_ras_n  <= 1'b1;
            sd_cas_n  <= 1'b1;
            sd_we_n   <= 1'b1;
            sd_addr   <= '0;
            sd_ba     <= '0;
            init_done <= 1'b0;
        end else begin
            sd_cke    <= cke_d;
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= cmd_d;
            sd_addr   <= addr_d;
            sd_ba     <= ba_d;
            init_done <= done_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: default-timing instance plus a long refresh sweep instance.
module tb_sdram_init_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;

    logic        cke1, cs1, ras1, cas1, we1, done1;
    logic [1:0]  ba1;
    logic [12:0] addr1;
    logic [3:0]  st1;
    logic        cke2, cs2, ras2, cas2, we2, done2;
    logic [1:0]  ba2;
    logic [12:0] addr2;
    logic [3:0]  st2;

    int checks = 0;
    int failures = 0;

    // Per-cycle capture; index is the cycle number relative to the start of run_seq
    logic [3:0]  cmd_a[0:199];
    logic        cke_a[0:199];
    logic        done_a[0:199];
    logic [12:0] addr_a[0:199];
    logic [1:0]  ba_a[0:199];
    logic [3:0]  cmd_b[0:199];
    logic        done_b[0:199];

    sdram_init_seq #(.CLK_MHZ(10), .POWERUP_US(1)) dut1 (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .sd_cke(cke1), .sd_cs_n(cs1), .sd_ras_n(ras1), .sd_cas_n(cas1), .sd_we_n(we1),
        .sd_ba(ba1), .sd_addr(addr1), .init_done(done1), .dbg_state(st1)
    );

    sdram_init_seq #(.CLK_MHZ(10), .POWERUP_US(1), .REFRESH_COUNT(8), .TRFC(7)) dut2 (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .sd_cke(cke2), .sd_cs_n(cs2), .sd_ras_n(ras2), .sd_cas_n(cas2), .sd_we_n(we2),
        .sd_ba(ba2), .sd_addr(addr2), .init_done(done2), .dbg_state(st2)
    );

    always #5 clk = ~clk;

    // Expected {init_done, cke, cmd} of the default instance, cycle 0 = first lock sample
    function automatic logic [5:0] nom_exp(input int c);
        if (c < 3)              return {1'b0, 1'b0, 4'b1111};
        if (c >= 36)            return {1'b1, 1'b1, 4'b1111};
        if (c == 13)            return {1'b0, 1'b1, 4'b0010};
        if (c == 16 || c == 25) return {1'b0, 1'b1, 4'b0001};
        if (c == 34)            return {1'b0, 1'b1, 4'b0000};
        return {1'b0, 1'b1, 4'b0111};
    endfunction

    function automatic logic [12:0] nom_addr(input int c);
        if (c == 13) return 13'h400;
        if (c == 34) return 13'h033;
        return 13'h000;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Drives lock/reset per cycle and records outputs sampled 1 time unit after each edge
    task automatic run_seq(input int n, input int drop_at, input int rise_at, input int rst_at);
        for (int i = 0; i < n; i++) begin
            pll_locked = (drop_at < 0 || i < drop_at || i >= rise_at) ? 1'b1 : 1'b0;
            rst = (i == rst_at) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cmd_a[i]  = {cs1, ras1, cas1, we1};
            cke_a[i]  = cke1;
            done_a[i] = done1;
            addr_a[i] = addr1;
            ba_a[i]   = ba1;
            cmd_b[i]  = {cs2, ras2, cas2, we2};
            done_b[i] = done2;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({done1, cke1, cs1, ras1, cas1, we1} !== 6'b001111) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 001111", {done1, cke1, cs1, ras1, cas1, we1});
        end
        checks++;
        if (addr1 !== 13'h0 || ba1 !== 2'h0) begin
            failures++;
            $display("FAIL reset_addr: got addr=%h ba=%h want 0/0", addr1, ba1);
        end
        checks++;
        if (st1 !== 4'd0 || st2 !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d/%0d want 0/0", st1, st2);
        end
    endtask

    task automatic test_no_lock();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if ({done1, cke1, cs1, ras1, cas1, we1} !== 6'b001111 || addr1 !== 13'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_lock_idle: %0d cycles left reset values, want 0", bad);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        run_seq(46, -1, -1, -1);
        for (int c = 0; c < 46; c++) begin
            checks++;
            if ({done_a[c], cke_a[c], cmd_a[c]} !== nom_exp(c)) begin
                failures++;
                $display("FAIL nominal_cmd c=%0d: got %b want %b", c, {done_a[c], cke_a[c], cmd_a[c]}, nom_exp(c));
            end
            checks++;
            if (addr_a[c] !== nom_addr(c) || ba_a[c] !== 2'b00) begin
                failures++;
                $display("FAIL nominal_addr c=%0d: got %h/%h want %h/0", c, addr_a[c], ba_a[c], nom_addr(c));
            end
        end
    endtask

    task automatic test_lock_loss_mid();
        do_reset();
        run_seq(90, 20, 40, -1);
        for (int c = 0; c < 90; c++) begin
            logic [5:0] e;
            if (c >= 20 && c < 23) continue;
            e = (c < 20) ? nom_exp(c) : (c < 40) ? 6'b001111 : nom_exp(c - 40);
            checks++;
            if ({done_a[c], cke_a[c], cmd_a[c]} !== e) begin
                failures++;
                $display("FAIL lockloss_mid c=%0d: got %b want %b", c, {done_a[c], cke_a[c], cmd_a[c]}, e);
            end
        end
        checks++;
        if (cmd_a[53] !== 4'b0010 || addr_a[53] !== 13'h400) begin
            failures++;
            $display("FAIL lockloss_mid_pre: got cmd=%b addr=%h want 0010/400", cmd_a[53], addr_a[53]);
        end
    endtask

    task automatic test_lock_loss_done();
        int refs = 0;
        do_reset();
        run_seq(170, 100, 120, -1);
        checks++;
        if (done_a[99] !== 1'b1) begin
            failures++;
            $display("FAIL done_before_loss: got %b want 1", done_a[99]);
        end
        for (int c = 103; c < 170; c++) begin
            logic [5:0] e;
            e = (c < 120) ? 6'b001111 : nom_exp(c - 120);
            checks++;
            if ({done_a[c], cke_a[c], cmd_a[c]} !== e) begin
                failures++;
                $display("FAIL lockloss_done c=%0d: got %b want %b", c, {done_a[c], cke_a[c], cmd_a[c]}, e);
            end
            if (cmd_a[c] === 4'b0001) refs++;
        end
        checks++;
        if (refs != 2) begin
            failures++;
            $display("FAIL relock_refresh_count: got %0d want 2", refs);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_seq(70, -1, -1, 18);
        for (int c = 0; c < 70; c++) begin
            logic [5:0] e;
            e = (c < 18) ? nom_exp(c) : (c == 18) ? 6'b001111 : nom_exp(c - 19);
            checks++;
            if ({done_a[c], cke_a[c], cmd_a[c]} !== e) begin
                failures++;
                $display("FAIL reset_mid c=%0d: got %b want %b", c, {done_a[c], cke_a[c], cmd_a[c]}, e);
            end
        end
        checks++;
        if (addr_a[18] !== 13'h0 || cmd_a[32] !== 4'b0010 || done_a[55] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_points: got addr18=%h cmd32=%b done55=%b want 0/0010/1",
                     addr_a[18], cmd_a[32], done_a[55]);
        end
    endtask

    task automatic test_param_sweep();
        int refs = 0;
        int last = -1;
        int lmr_at = -1;
        int bad_gap = 0;
        do_reset();
        run_seq(90, -1, -1, -1);
        for (int c = 0; c < 90; c++) begin
            if (cmd_b[c] === 4'b0001) begin
                if (refs == 0 && c != 16) bad_gap++;
                if (refs > 0 && c - last != 7) bad_gap++;
                if (lmr_at >= 0) bad_gap++;
                refs++;
                last = c;
            end
            if (cmd_b[c] === 4'b0000 && lmr_at < 0) lmr_at = c;
        end
        checks++;
        if (refs != 8) begin
            failures++;
            $display("FAIL sweep_refresh_count: got %0d want 8", refs);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL sweep_refresh_spacing: got %0d bad refreshes want 0", bad_gap);
        end
        checks++;
        if (lmr_at != 72) begin
            failures++;
            $display("FAIL sweep_lmr_cycle: got %0d want 72", lmr_at);
        end
        checks++;
        if (cmd_b[13] !== 4'b0010 || done_b[73] !== 1'b0 || done_b[74] !== 1'b1) begin
            failures++;
            $display("FAIL sweep_pre_done: got pre=%b done73=%b done74=%b want 0010/0/1",
                     cmd_b[13], done_b[73], done_b[74]);
        end
    endtask

    initial begin
        test_reset();
        test_no_lock();
        test_nominal();
        test_lock_loss_mid();
        test_lock_loss_done();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
